// File: rtl/trigger_capture_ctrl.sv
// Oscilloscope acquisition sequencer: circular pre-trigger buffer fill, level/slope
// or forced trigger detection, post-trigger capture and trigger/start address report.
module trigger_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic              Main_CLK,
    input  logic              Reset,
    input  logic              Sample_Valid,
    input  logic [DATA_W-1:0] Sample_In,
    input  logic              Arm,
    input  logic              Abort,
    input  logic              Force_Trig,
    input  logic [DATA_W-1:0] Trig_Level,
    input  logic              Trig_Slope,
    input  logic [ADDR_W-1:0] Pretrig,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [DATA_W-1:0] Wr_Data,
    output logic [ADDR_W-1:0] Trig_Addr,
    output logic [ADDR_W-1:0] Start_Addr,
    output logic              Busy,
    output logic              Done,
    output logic [2:0]        State
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  pre_cnt_q, post_cnt_q, post_init;
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q, force_pend_q;
    logic              level_hit, trig_hit, capturing;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q, trig_addr_q, start_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    assign post_init = CNT_W'(DEPTH) - {1'b0, Pretrig} - CNT_W'(1);
    assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);

    always_ff @(posedge Main_CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        trig_hit  = 1'b0;
        level_hit = Trig_Slope ? ((prev_q >= Trig_Level) && (Sample_In <  Trig_Level))
                               : ((prev_q <  Trig_Level) && (Sample_In >= Trig_Level));
        if (Abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (Arm) state_nxt = (Pretrig != '0) ? S_PRE : S_WAIT;
                S_PRE: if (Sample_Valid && (pre_cnt_q + CNT_W'(1) == {1'b0, Pretrig}))
                    state_nxt = S_WAIT;
                S_WAIT: if (Sample_Valid && (force_pend_q || (prev_valid_q && level_hit))) begin
                    trig_hit  = 1'b1;
                    state_nxt = (post_init == '0) ? S_DONE : S_POST;
                end
                S_POST: if (Sample_Valid && (post_cnt_q == CNT_W'(1))) state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        State = state_q;
        Busy  = capturing;
        Done  = (state_q == S_DONE);
    end

    // Abort dominates everything; otherwise samples are only taken while capturing.
    always_ff @(posedge Main_CLK or negedge Reset) begin
        if (!Reset) begin
            ptr_q        <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (Abort) begin
                trig_addr_q  <= '0;
                start_addr_q <= '0;
                force_pend_q <= 1'b0;
            end else if (capturing) begin
                if (Sample_Valid) begin
                    wr_en_q      <= 1'b1;
                    wr_addr_q    <= ptr_q;
                    wr_data_q    <= Sample_In;
                    ptr_q        <= ptr_q + ADDR_W'(1);
                    prev_q       <= Sample_In;
                    prev_valid_q <= 1'b1;
                    if (state_q == S_PRE)  pre_cnt_q  <= pre_cnt_q + CNT_W'(1);
                    if (state_q == S_POST) post_cnt_q <= post_cnt_q - CNT_W'(1);
                end
                if (trig_hit) begin
                    trig_addr_q  <= ptr_q;
                    start_addr_q <= ptr_q - Pretrig;
                    post_cnt_q   <= post_init;
                    force_pend_q <= 1'b0;
                end else if ((state_q == S_WAIT) && Force_Trig) begin
                    force_pend_q <= 1'b1;
                end
            end else if (Arm) begin
                ptr_q        <= '0;
                pre_cnt_q    <= '0;
                prev_valid_q <= 1'b0;
                force_pend_q <= 1'b0;
                trig_addr_q  <= '0;
                start_addr_q <= '0;
            end
        end
    end

    assign Wr_En      = wr_en_q;
    assign Wr_Addr    = wr_addr_q;
    assign Wr_Data    = wr_data_q;
    assign Trig_Addr  = trig_addr_q;
    assign Start_Addr = start_addr_q;

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Bench for trigger_capture_ctrl: directed vector table, hand-written corner sequences
// and randomized traffic against a sample-count based reference model.
module tb_trigger_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              Main_CLK = 1'b0;
    logic              Reset = 1'b0;
    logic              Sample_Valid = 1'b0;
    logic [DATA_W-1:0] Sample_In = '0;
    logic              Arm = 1'b0, Abort = 1'b0, Force_Trig = 1'b0;
    logic [DATA_W-1:0] Trig_Level = '0;
    logic              Trig_Slope = 1'b0;
    logic [ADDR_W-1:0] Pretrig = '0;
    logic              Wr_En, Busy, Done;
    logic [ADDR_W-1:0] Wr_Addr, Trig_Addr, Start_Addr;
    logic [DATA_W-1:0] Wr_Data;
    logic [2:0]        State;

    int checks = 0;
    int failures = 0;

    trigger_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Main_CLK(Main_CLK), .Reset(Reset), .Sample_Valid(Sample_Valid), .Sample_In(Sample_In),
        .Arm(Arm), .Abort(Abort), .Force_Trig(Force_Trig), .Trig_Level(Trig_Level),
        .Trig_Slope(Trig_Slope), .Pretrig(Pretrig), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr),
        .Wr_Data(Wr_Data), .Trig_Addr(Trig_Addr), .Start_Addr(Start_Addr), .Busy(Busy),
        .Done(Done), .State(State)
    );

    always #5 Main_CLK = ~Main_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: phase per the State encoding, addresses derived from samples-since-arm.
    int m_phase, m_n, m_prev, m_left, m_ta, m_sa, m_wa, m_wd;
    bit m_hp, m_fp, m_we;

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_prev = 0; m_left = 0; m_ta = 0; m_sa = 0;
        m_wa = 0; m_wd = 0; m_hp = 0; m_fp = 0; m_we = 0;
    endtask

    task automatic model_step();
        int ph0 = m_phase;
        int lv = int'(Trig_Level);
        int s = int'(Sample_In);
        int pt = int'(Pretrig);
        bit hit = 0;
        m_we = 0;
        if (Abort) begin
            m_phase = 0; m_ta = 0; m_sa = 0; m_fp = 0;
        end else if (ph0 == 0 || ph0 == 4) begin
            if (Arm) begin
                m_n = 0; m_hp = 0; m_fp = 0; m_ta = 0; m_sa = 0;
                m_phase = (pt != 0) ? 1 : 2;
            end
        end else begin
            if (Sample_Valid) begin
                m_we = 1; m_wa = m_n % DEPTH; m_wd = s;
                if (ph0 == 1) begin
                    if (m_n + 1 == pt) m_phase = 2;
                end else if (ph0 == 2) begin
                    if (m_fp) hit = 1;
                    else if (m_hp) hit = Trig_Slope ? (m_prev >= lv && s < lv) : (m_prev < lv && s >= lv);
                    if (hit) begin
                        m_ta = m_wa;
                        m_sa = (m_wa - pt + DEPTH) % DEPTH;
                        m_left = DEPTH - pt - 1;
                        m_fp = 0;
                        m_phase = (m_left == 0) ? 4 : 3;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = 4;
                end
                m_n++; m_prev = s; m_hp = 1;
            end
            if (ph0 == 2 && Force_Trig && !hit) m_fp = 1;
        end
    endtask

    task automatic compare_model();
        chk("state", State, m_phase);
        chk("wr_en", Wr_En, m_we);
        if (m_we) begin
            chk("wr_addr", Wr_Addr, m_wa);
            chk("wr_data", Wr_Data, m_wd);
        end
        chk("trig_addr", Trig_Addr, m_ta);
        chk("start_addr", Start_Addr, m_sa);
        chk("busy", Busy, (m_phase >= 1 && m_phase <= 3));
        chk("done", Done, (m_phase == 4));
    endtask

    task automatic cyc(input bit v, input int s, input bit a = 0, input bit ab = 0, input bit f = 0);
        Sample_Valid = v; Sample_In = DATA_W'(s); Arm = a; Abort = ab; Force_Trig = f;
        @(posedge Main_CLK);
        model_step();
        @(negedge Main_CLK);
        compare_model();
    endtask

    task automatic do_reset();
        Reset = 1'b0; Sample_Valid = 0; Arm = 0; Abort = 0; Force_Trig = 0;
        repeat (2) @(negedge Main_CLK);
        model_reset();
        compare_model();
        Reset = 1'b1;
    endtask

    typedef struct {
        bit arm, abort, force_t, valid;
        int smp, pt, st;
        bit we;
        int wa, wd, ta, sa;
    } vec_t;

    function automatic vec_t mk(bit arm, bit abort, bit force_t, bit valid, int smp, int pt,
                                int st, bit we, int wa, int wd, int ta, int sa);
        vec_t r;
        r.arm = arm; r.abort = abort; r.force_t = force_t; r.valid = valid; r.smp = smp;
        r.pt = pt; r.st = st; r.we = we; r.wa = wa; r.wd = wd; r.ta = ta; r.sa = sa;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        int writes;
        bit seen_done;
        //          arm ab fo v  smp  pt st we wa  wd ta sa
        tbl.push_back(mk(1, 0, 0, 0,   0, 2, 1, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 200, 2, 1, 1, 0, 200, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 150, 2, 2, 1, 1, 150, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 120, 2, 2, 1, 2, 120, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 2, 2, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  99, 2, 3, 1, 3,  99, 3, 1));
        tbl.push_back(mk(1, 0, 0, 0,   0, 2, 3, 0, 0,   0, 3, 1));
        tbl.push_back(mk(0, 0, 1, 0,   0, 2, 3, 0, 0,   0, 3, 1));
        tbl.push_back(mk(0, 0, 0, 1,   5, 2, 3, 1, 4,   5, 3, 1));
        tbl.push_back(mk(0, 1, 0, 1,   7, 2, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,   8, 2, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0,   0, 2, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0, 2, 1, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  50, 2, 1, 1, 0,  50, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,   0, 2, 0, 0, 0,   0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,   0, 0, 2, 0, 0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  50, 0, 2, 1, 0,  50, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  40, 0, 2, 1, 1,  40, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 150, 0, 2, 1, 2, 150, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  90, 0, 3, 1, 3,  90, 3, 3));

        do_reset();
        Trig_Level = 12'd100; Trig_Slope = 1'b1;
        foreach (tbl[i]) begin
            Arm = tbl[i].arm; Abort = tbl[i].abort; Force_Trig = tbl[i].force_t;
            Sample_Valid = tbl[i].valid; Sample_In = DATA_W'(tbl[i].smp);
            Pretrig = ADDR_W'(tbl[i].pt);
            @(posedge Main_CLK);
            @(negedge Main_CLK);
            chk($sformatf("tbl%0d_state", i), State, tbl[i].st);
            chk($sformatf("tbl%0d_wr_en", i), Wr_En, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_wr_addr", i), Wr_Addr, tbl[i].wa);
                chk($sformatf("tbl%0d_wr_data", i), Wr_Data, tbl[i].wd);
            end
            chk($sformatf("tbl%0d_trig_addr", i), Trig_Addr, tbl[i].ta);
            chk($sformatf("tbl%0d_start_addr", i), Start_Addr, tbl[i].sa);
            chk($sformatf("tbl%0d_busy", i), Busy, (tbl[i].st >= 1 && tbl[i].st <= 3));
            chk($sformatf("tbl%0d_done", i), Done, (tbl[i].st == 4));
        end

        // Rising ramp through a 4-deep pre-trigger window
        do_reset();
        Pretrig = 4'd4; Trig_Level = 12'd10; Trig_Slope = 1'b0;
        cyc(0, 0, 1);
        for (int k = 0; k <= 21; k++) begin
            cyc(1, k);
            chk("ramp_addr", Wr_Addr, k % DEPTH);
            chk("ramp_data", Wr_Data, k);
            if (k == 3) chk("ramp_to_wait", State, 2);
            if (k == 10) begin
                chk("ramp_trig", Trig_Addr, 10);
                chk("ramp_start", Start_Addr, 6);
            end
            if (k == 20) chk("ramp_not_done", Done, 0);
        end
        chk("ramp_done", Done, 1);

        // Forced trigger on a flat input that never crosses the level
        Trig_Level = 12'd4000;
        cyc(0, 0, 1);
        for (int k = 0; k < 7; k++) cyc(1, 5);
        chk("force_still_wait", State, 2);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 5);
        chk("force_trig_addr", Trig_Addr, 7);
        chk("force_start_addr", Start_Addr, 3);
        writes = 1;
        seen_done = 0;
        for (int k = 0; k < 100 && !seen_done; k++) begin
            cyc(1, 5);
            if (Wr_En) writes++;
            if (Done) seen_done = 1;
        end
        chk("force_reached_done", seen_done, 1);
        chk("force_post_writes", writes, DEPTH - 4);

        // Pretrig=0 arms straight into WAIT; Pretrig=15 triggers straight into DONE
        cyc(0, 0, 0, 1);
        Pretrig = 4'd0;
        cyc(0, 0, 1);
        chk("pt0_wait", State, 2);
        cyc(0, 0, 0, 1);
        Pretrig = 4'd15;
        cyc(0, 0, 1);
        for (int k = 0; k < 15; k++) cyc(1, 5);
        chk("pt15_wait", State, 2);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 5);
        chk("pt15_direct_done", State, 4);
        chk("pt15_write", Wr_En, 1);
        chk("pt15_trig", Trig_Addr, 15);
        chk("pt15_start", Start_Addr, 0);
        cyc(1, 5);
        chk("pt15_no_more", Wr_En, 0);

        // Asynchronous reset dropped between clock edges mid-WAIT
        cyc(0, 0, 0, 1);
        Pretrig = 4'd0; Trig_Level = 12'd4000;
        cyc(0, 0, 1);
        cyc(1, 9);
        cyc(1, 11);
        #2 Reset = 1'b0;
        #1;
        chk("arst_state", State, 0);
        chk("arst_wr_en", Wr_En, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_wr_addr", Wr_Addr, 0);
        model_reset();
        Sample_Valid = 1'b1;
        @(posedge Main_CLK);
        @(negedge Main_CLK);
        chk("arst_hold_wr_en", Wr_En, 0);
        Reset = 1'b1;
        cyc(1, 3);
        cyc(1, 4);

        // Randomized traffic against the model
        for (int blk = 0; blk < 4; blk++) begin
            cyc(0, 0, 0, 1);
            Pretrig = ADDR_W'($urandom_range(0, DEPTH - 1));
            Trig_Level = DATA_W'($urandom_range(0, 4095));
            Trig_Slope = 1'($urandom % 2);
            for (int k = 0; k < 300; k++)
                cyc(1'($urandom % 2), int'($urandom % 4096), ($urandom % 12) == 0,
                    ($urandom % 200) == 0, ($urandom % 25) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
